temp_sensor_filter: RTL and testbench



---
 rtl/temp_sensor_filter.sv | 100 ++++++++++
 tb/tb_temp_sensor_filter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/temp_sensor_filter.sv
// Moving-average front end for the thermostat: windowed sum of raw Q6.2 readings,
// converted to a rounded, clamped 5-bit integer degree value with staleness detection.
module temp_sensor_filter #(
  parameter int WINDOW_LOG2 = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_data,
  input  logic       raw_valid,
  output logic [4:0] temperature,
  output logic       temp_valid,
  output logic       stale,
  output logic       sat
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << WINDOW_LOG2;
  localparam int SUM_W  = DATA_W + WINDOW_LOG2;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t                   state_q, state_d;
  logic [DATA_W-1:0]        buf_p0 [DEPTH];
  logic [SUM_W-1:0]         sum_p0;
  logic [WINDOW_LOG2-1:0]   wp_p0;
  logic [CNT_W-1:0]         cnt_p0;
  logic [4:0]               temp_p1;
  logic                     sat_p1;
  logic                     vld_p1;
  logic                     stale_p0;

  // Truncating window average in Q6.2, then round half up to whole degrees (0..64).
  function automatic logic [6:0] round_deg(input logic [SUM_W-1:0] sum);
    logic [DATA_W-1:0] avg_q2;
    logic [DATA_W:0]   biased;
    avg_q2 = DATA_W'(sum >> WINDOW_LOG2);
    biased = {1'b0, avg_q2} + (DATA_W+1)'(2);
    return 7'(biased >> 2);
  endfunction

  // Clamp to the 5-bit controller range; bit 5 flags that clamping occurred.
  function automatic logic [5:0] sat_deg(input logic [6:0] deg);
    if (deg > 7'd31) return {1'b1, 5'd31};
    return {1'b0, deg[4:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    if (state_q == FILL && raw_valid && wp_p0 == WINDOW_LOG2'(DEPTH - 1))
      state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  assign stale_p0 = (cnt_p0 == CNT_W'(TIMEOUT));

  // Stage p0: sample window, running sum and staleness counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_p0[i] <= '0;
      sum_p0 <= '0;
      wp_p0  <= '0;
      cnt_p0 <= '0;
    end else begin
      if (raw_valid) begin
        buf_p0[wp_p0] <= raw_data;
        sum_p0        <= sum_p0 - SUM_W'(buf_p0[wp_p0]) + SUM_W'(raw_data);
        wp_p0         <= wp_p0 + 1'b1;
        cnt_p0        <= '0;
      end else if (!stale_p0) begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Stage p1: conversion; holds its value in FILL and while stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_p1 <= '0;
      sat_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= (state_q == RUN) && !stale_p0;
      if (state_q == RUN && !stale_p0) begin
        {sat_p1, temp_p1} <= sat_deg(round_deg(sum_p0));
      end
    end
  end

  assign temperature = temp_p1;
  assign sat         = sat_p1;
  assign stale       = stale_p0;
  assign temp_valid  = vld_p1 && !stale_p0;

endmodule

// File: tb/tb_temp_sensor_filter.sv
// Directed bench for temp_sensor_filter with a short staleness timeout.
module tb_temp_sensor_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw_data;
  logic       raw_valid;
  logic [4:0] temperature;
  logic       temp_valid;
  logic       stale;
  logic       sat;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  temp_sensor_filter #(.WINDOW_LOG2(2), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_data   (raw_data),
    .raw_valid  (raw_valid),
    .temperature(temperature),
    .temp_valid (temp_valid),
    .stale      (stale),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [7:0] d);
    raw_valid = v;
    raw_data  = d;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic window(input logic [7:0] d);
    for (int i = 0; i < 4; i++) step(1'b1, d);
    step(1'b0, 8'd0);
  endtask

  initial begin
    rst = 1'b1; raw_valid = 1'b0; raw_data = 8'd0;
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    rst = 1'b0;
    check("rst_temp", temperature, 0);
    check("rst_valid", temp_valid, 0);
    check("rst_stale", stale, 0);
    check("rst_sat", sat, 0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'd80);
      check("fill_valid_low", temp_valid, 0);
    end
    step(1'b0, 8'd0);
    check("first_temp", temperature, 20);
    check("first_valid", temp_valid, 1);
    check("first_sat", sat, 0);

    step(1'b1, 8'd96);
    step(1'b0, 8'd0);
    check("one_96", temperature, 21);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd96);
    step(1'b0, 8'd0);
    check("all_96", temperature, 24);

    window(8'd74);
    check("round_up", temperature, 19);
    window(8'd73);
    check("round_down", temperature, 18);

    window(8'd200);
    check("sat_temp", temperature, 31);
    check("sat_flag", sat, 1);
    window(8'd88);
    check("unsat_temp", temperature, 22);
    check("unsat_flag", sat, 0);

    // Last sample of this window is accepted; the following idle step is edge 1.
    window(8'd80);
    check("pre_stale_temp", temperature, 20);
    for (int i = 2; i <= 15; i++) step(1'b0, 8'd0);
    check("stale_edge15", stale, 0);
    check("valid_edge15", temp_valid, 1);
    step(1'b0, 8'd0);
    check("stale_edge16", stale, 1);
    check("stale_valid", temp_valid, 0);
    check("stale_hold", temperature, 20);
    step(1'b1, 8'd80);
    check("unstale_now", stale, 0);
    check("unstale_valid_lag", temp_valid, 0);
    step(1'b0, 8'd0);
    check("unstale_valid", temp_valid, 1);
    check("unstale_temp", temperature, 20);

    step(1'b1, 8'd40);
    step(1'b1, 8'd40);
    rst = 1'b1;
    step(1'b1, 8'd200);
    rst = 1'b0;
    check("mid_rst_temp", temperature, 0);
    check("mid_rst_valid", temp_valid, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_stale", stale, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd120);
      check("refill_valid_low", temp_valid, 0);
    end
    step(1'b1, 8'd120);
    check("refill_4th_edge", temp_valid, 0);
    step(1'b0, 8'd0);
    check("refill_valid", temp_valid, 1);
    check("refill_temp", temperature, 30);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
